// File: rtl/mpd_prt_sequencer_pkg.sv
// Shared types and constants for the MPD packet sequencer.
// Holds the state encoding, the IP field width and the slot-width helper.
package mpd_prt_sequencer_pkg;

  localparam int IP_W = 32;

  typedef enum logic [2:0] {
    IDLE, WRITE, FINISH, CHECK, WAIT_BF, RD_START, RD_STREAM, INVAL
  } seq_state_t;

  // Plain vector constants so the state register stays a simple logic vector.
  localparam logic [2:0] ST_IDLE      = 3'(IDLE);
  localparam logic [2:0] ST_WRITE     = 3'(WRITE);
  localparam logic [2:0] ST_FINISH    = 3'(FINISH);
  localparam logic [2:0] ST_CHECK     = 3'(CHECK);
  localparam logic [2:0] ST_WAIT_BF   = 3'(WAIT_BF);
  localparam logic [2:0] ST_RD_START  = 3'(RD_START);
  localparam logic [2:0] ST_RD_STREAM = 3'(RD_STREAM);
  localparam logic [2:0] ST_INVAL     = 3'(INVAL);

  function automatic int slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/mpd_prt_sequencer_if.sv
// Bundle of input FIFO, PRT method, bloom filter and output FIFO signals.
// master = the sequencer, slave = the surrounding datapath.
interface mpd_prt_sequencer_if
  import mpd_prt_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16
);
  localparam int SLOT_W = slot_w(NUM_SLOTS);

  logic                  in_valid, in_ready, in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  is_prt_slot_free, RDY_is_prt_slot_free;
  logic                  EN_start_writing_prt_entry, RDY_start_writing_prt_entry;
  logic [SLOT_W-1:0]     start_writing_prt_entry;
  logic                  EN_write_prt_entry, RDY_write_prt_entry;
  logic [DATA_WIDTH-1:0] write_prt_entry_data;
  logic                  EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
  logic                  EN_invalidate_prt_entry, RDY_invalidate_prt_entry;
  logic [SLOT_W-1:0]     invalidate_prt_entry_slot;
  logic                  EN_start_reading_prt_entry, RDY_start_reading_prt_entry;
  logic [SLOT_W-1:0]     start_reading_prt_entry_slot;
  logic                  EN_read_prt_entry, RDY_read_prt_entry;
  logic [DATA_WIDTH:0]   read_prt_entry;
  logic                  bf_enable, bf_busy;
  logic [IP_W-1:0]       bf_src_ip, bf_dest_ip;
  logic [SLOT_W-1:0]     bf_tag, bf_out_tag;
  logic                  bf_output_valid, bf_safe;
  logic                  out_valid, out_ready, out_last;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  in_valid, in_last, in_data, is_prt_slot_free, RDY_is_prt_slot_free,
           RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
           RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry,
           RDY_start_reading_prt_entry, RDY_read_prt_entry, read_prt_entry,
           bf_busy, bf_output_valid, bf_safe, bf_out_tag, out_ready,
    output in_ready, EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
           EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
           EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
           bf_enable, bf_src_ip, bf_dest_ip, bf_tag, out_valid, out_last, out_data
  );

  modport slave (
    output in_valid, in_last, in_data, is_prt_slot_free, RDY_is_prt_slot_free,
           RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
           RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry,
           RDY_start_reading_prt_entry, RDY_read_prt_entry, read_prt_entry,
           bf_busy, bf_output_valid, bf_safe, bf_out_tag, out_ready,
    input  in_ready, EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
           EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
           EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
           bf_enable, bf_src_ip, bf_dest_ip, bf_tag, out_valid, out_last, out_data
  );

endinterface

// File: rtl/mpd_prt_sequencer_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_i, holds at all-ones.
// Single-cycle update, never stalls.
module mpd_prt_sequencer_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/mpd_prt_sequencer.sv
// Per-packet controller: store packet in a PRT slot, ask the bloom filter, then forward or drop.
// One packet in flight; input stalls outside WRITE, readout follows out_ready.
module mpd_prt_sequencer
  import mpd_prt_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLOTS   = 16,
  parameter int MAX_BEATS   = 64,
  parameter int SRC_IP_BEAT = 3,
  parameter int DST_IP_BEAT = 4,
  parameter int BF_TIMEOUT  = 255,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mpd_prt_sequencer_if.master bus,
  output logic [CNT_W-1:0]    fwd_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic [CNT_W-1:0]    timeout_count
);
  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int TMR_W  = $clog2(BF_TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              ovf_q, ovf_d, dst_seen_q, dst_seen_d;
  logic [IP_W-1:0]   src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              beat_acc, fwd_inc, drop_inc, to_inc;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    beat_cnt_d = beat_cnt_q;
    ovf_d      = ovf_q;
    dst_seen_d = dst_seen_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    timer_d    = timer_q;
    beat_acc   = 1'b0;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    to_inc     = 1'b0;
    bus.in_ready                    = 1'b0;
    bus.EN_start_writing_prt_entry  = 1'b0;
    bus.EN_write_prt_entry          = 1'b0;
    bus.EN_finish_writing_prt_entry = 1'b0;
    bus.EN_invalidate_prt_entry     = 1'b0;
    bus.EN_start_reading_prt_entry  = 1'b0;
    bus.EN_read_prt_entry           = 1'b0;
    bus.bf_enable                   = 1'b0;
    bus.out_valid                   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.EN_start_writing_prt_entry = bus.in_valid & bus.is_prt_slot_free &
                                         bus.RDY_is_prt_slot_free & bus.RDY_start_writing_prt_entry;
        if (bus.EN_start_writing_prt_entry) begin
          slot_d     = bus.start_writing_prt_entry;
          beat_cnt_d = '0;
          ovf_d      = 1'b0;
          dst_seen_d = 1'b0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.in_ready = bus.RDY_write_prt_entry;
        beat_acc     = bus.in_valid & bus.RDY_write_prt_entry;
        if (beat_acc) begin
          // Beat count stops at MAX_BEATS; later beats are swallowed and flag overflow.
          if (beat_cnt_q < BEAT_W'(MAX_BEATS)) begin
            bus.EN_write_prt_entry = 1'b1;
            beat_cnt_d             = beat_cnt_q + BEAT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (beat_cnt_q == BEAT_W'(SRC_IP_BEAT)) src_ip_d = bus.in_data[IP_W-1:0];
          if (beat_cnt_q == BEAT_W'(DST_IP_BEAT)) begin
            dst_ip_d   = bus.in_data[IP_W-1:0];
            dst_seen_d = 1'b1;
          end
          if (bus.in_last) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        bus.EN_finish_writing_prt_entry = bus.RDY_finish_writing_prt_entry;
        if (bus.RDY_finish_writing_prt_entry)
          state_d = (dst_seen_q && !ovf_q) ? ST_CHECK : ST_INVAL;
      end
      ST_CHECK: begin
        bus.bf_enable = ~bus.bf_busy;
        if (!bus.bf_busy) begin
          timer_d = '0;
          state_d = ST_WAIT_BF;
        end
      end
      ST_WAIT_BF: begin
        timer_d = timer_q + TMR_W'(1);
        // A matching verdict takes priority over a timeout in the same cycle.
        if (bus.bf_output_valid && (bus.bf_out_tag == slot_q)) begin
          state_d = bus.bf_safe ? ST_RD_START : ST_INVAL;
        end else if (timer_d == TMR_W'(BF_TIMEOUT)) begin
          state_d = ST_INVAL;
          to_inc  = 1'b1;
        end
      end
      ST_RD_START: begin
        bus.EN_start_reading_prt_entry = bus.RDY_start_reading_prt_entry;
        if (bus.RDY_start_reading_prt_entry) state_d = ST_RD_STREAM;
      end
      ST_RD_STREAM: begin
        bus.out_valid         = bus.RDY_read_prt_entry;
        bus.EN_read_prt_entry = bus.RDY_read_prt_entry & bus.out_ready;
        if (bus.EN_read_prt_entry && bus.read_prt_entry[DATA_WIDTH]) begin
          fwd_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_INVAL: begin
        bus.EN_invalidate_prt_entry = bus.RDY_invalidate_prt_entry;
        if (bus.RDY_invalidate_prt_entry) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
      dst_seen_q <= 1'b0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
      dst_seen_q <= dst_seen_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.write_prt_entry_data         = bus.in_data;
  assign bus.invalidate_prt_entry_slot    = slot_q;
  assign bus.start_reading_prt_entry_slot = slot_q;
  assign bus.bf_src_ip                    = src_ip_q;
  assign bus.bf_dest_ip                   = dst_ip_q;
  assign bus.bf_tag                       = slot_q;
  assign bus.out_data                     = bus.read_prt_entry[DATA_WIDTH-1:0];
  assign bus.out_last                     = bus.read_prt_entry[DATA_WIDTH];

  mpd_prt_sequencer_sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(fwd_inc), .count_o(fwd_count));
  mpd_prt_sequencer_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(drop_inc), .count_o(drop_count));
  mpd_prt_sequencer_sat_counter #(.CNT_W(CNT_W)) u_to_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(to_inc), .count_o(timeout_count));
endmodule

// File: tb/tb_mpd_prt_sequencer.sv
// Randomized bench: plays PRT, bloom filter and both FIFOs, and predicts each packet's fate.
// The packet-level model decides forward/drop/timeout from length and verdict timing alone.
module tb_mpd_prt_sequencer;
  import mpd_prt_sequencer_pkg::*;

  localparam int DW = 32, NS = 16, SW = 4, MAXB = 64, SRCB = 3, DSTB = 4, TO = 255, CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpd_prt_sequencer_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus ();
  logic [CW-1:0] fwd_count, drop_count, timeout_count;

  mpd_prt_sequencer #(
    .DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_BEATS(MAXB), .SRC_IP_BEAT(SRCB),
    .DST_IP_BEAT(DSTB), .BF_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fwd_count(fwd_count), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  int n_chk = 0, n_pass = 0;

  // Environment and model state for the packet in flight.
  logic [31:0] pkt[$];
  logic [31:0] wr_q[$];
  int n_beats, in_idx, out_idx, wait_k, verdict_d, bad_d, fin_cnt, exp_outcome;
  bit started, bf_fired, rd_open, done, verdict_safe, lookup_seen, lookup_exp, aborted;
  logic [SW-1:0] cur_slot;
  int m_fwd, m_drop, m_to;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic bit rb(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic clear_env();
    pkt.delete(); wr_q.delete();
    n_beats = 0; in_idx = 0; out_idx = 0; wait_k = 0; fin_cnt = 0;
    started = 0; bf_fired = 0; rd_open = 0; done = 0; lookup_seen = 0; aborted = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
    bus.is_prt_slot_free = 1; bus.RDY_is_prt_slot_free = 1;
    bus.RDY_start_writing_prt_entry = 1; bus.start_writing_prt_entry = '0;
    bus.RDY_write_prt_entry = 1; bus.RDY_finish_writing_prt_entry = 1;
    bus.RDY_invalidate_prt_entry = 1; bus.RDY_start_reading_prt_entry = 1;
    bus.RDY_read_prt_entry = 1; bus.read_prt_entry = '1;
    bus.bf_busy = 0; bus.bf_output_valid = 0; bus.bf_safe = 0; bus.bf_out_tag = '0;
    bus.out_ready = 1;
    @(negedge clk);
    chk("rst_strobes", {bus.EN_start_writing_prt_entry, bus.EN_write_prt_entry,
        bus.EN_finish_writing_prt_entry, bus.EN_invalidate_prt_entry,
        bus.EN_start_reading_prt_entry, bus.EN_read_prt_entry, bus.bf_enable,
        bus.in_ready, bus.out_valid}, 0);
    chk("rst_counters", {fwd_count, drop_count, timeout_count}, 0);
    chk("rst_ips", {bus.bf_src_ip, bus.bf_dest_ip}, 0);
    chk("rst_slot", {bus.bf_tag, bus.invalidate_prt_entry_slot}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_env();
    m_fwd = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic drive();
    if (bf_fired) wait_k++;
    bus.in_valid = (in_idx < n_beats) && rb(75);
    bus.in_data  = (in_idx < n_beats) ? pkt[in_idx] : 32'h0;
    bus.in_last  = (in_idx == n_beats - 1);
    bus.is_prt_slot_free = 1;
    bus.RDY_is_prt_slot_free = rb(80);
    bus.RDY_start_writing_prt_entry = rb(80);
    bus.start_writing_prt_entry = cur_slot;
    bus.RDY_write_prt_entry = rb(80);
    bus.RDY_finish_writing_prt_entry = rb(70);
    bus.RDY_invalidate_prt_entry = rb(70);
    bus.RDY_start_reading_prt_entry = rb(70);
    bus.RDY_read_prt_entry = rd_open && (out_idx < wr_q.size()) && rb(80);
    bus.read_prt_entry = (out_idx < wr_q.size()) ? {(out_idx == wr_q.size() - 1), wr_q[out_idx]} : '0;
    bus.out_ready = rb(50);
    bus.bf_busy = rb(30);
    bus.bf_output_valid = 0; bus.bf_out_tag = '0; bus.bf_safe = 0;
    if (bf_fired && verdict_d != 0 && wait_k == verdict_d) begin
      bus.bf_output_valid = 1; bus.bf_out_tag = cur_slot; bus.bf_safe = verdict_safe;
    end else if (bf_fired && bad_d != 0 && wait_k == bad_d) begin
      bus.bf_output_valid = 1; bus.bf_out_tag = cur_slot ^ 4'h6; bus.bf_safe = 1;
    end
  endtask

  task automatic sample();
    if (bus.EN_start_writing_prt_entry) begin
      chk("start_rdy", {bus.RDY_start_writing_prt_entry, bus.RDY_is_prt_slot_free,
          bus.is_prt_slot_free, bus.in_valid}, 4'hF);
      chk("start_once", started, 0);
      started = 1;
    end
    if (bus.in_ready) chk("in_ready_phase", started && (in_idx < n_beats), 1);
    if (bus.in_valid && bus.in_ready) begin
      chk("en_write", bus.EN_write_prt_entry, in_idx < MAXB);
      if (bus.EN_write_prt_entry) begin
        chk("wr_data", bus.write_prt_entry_data, pkt[in_idx]);
        chk("wr_rdy", bus.RDY_write_prt_entry, 1);
        wr_q.push_back(bus.write_prt_entry_data);
      end
      in_idx++;
    end else if (bus.EN_write_prt_entry) begin
      chk("wr_without_beat", bus.EN_write_prt_entry, 0);
    end
    if (bus.EN_finish_writing_prt_entry) begin
      chk("fin_rdy", bus.RDY_finish_writing_prt_entry, 1);
      chk("fin_after_last", in_idx, n_beats);
      fin_cnt++;
    end
    if (bus.bf_enable) begin
      chk("bf_lookup_expected", lookup_exp, 1);
      chk("bf_not_busy", bus.bf_busy, 0);
      chk("bf_once", lookup_seen, 0);
      chk("bf_tag", bus.bf_tag, cur_slot);
      if (lookup_exp) begin
        chk("bf_src", bus.bf_src_ip, pkt[SRCB]);
        chk("bf_dst", bus.bf_dest_ip, pkt[DSTB]);
      end
      lookup_seen = 1; bf_fired = 1; wait_k = 0;
    end
    if (bus.EN_start_reading_prt_entry) begin
      chk("rd_rdy", bus.RDY_start_reading_prt_entry, 1);
      chk("rd_expected", exp_outcome, 0);
      chk("rd_after_verdict", wait_k > verdict_d, 1);
      chk("rd_slot", bus.start_reading_prt_entry_slot, cur_slot);
      rd_open = 1;
    end
    if (bus.out_valid) chk("out_valid_when_fwd", rd_open, 1);
    if (bus.out_valid && bus.out_ready) begin
      chk("en_read", bus.EN_read_prt_entry, 1);
      if (out_idx < n_beats) chk("out_data", bus.out_data, pkt[out_idx]);
      else chk("out_overrun", out_idx, n_beats - 1);
      chk("out_last", bus.out_last, out_idx == n_beats - 1);
      if (bus.out_last) done = 1;
      out_idx++;
    end else if (bus.EN_read_prt_entry) begin
      chk("read_without_hs", bus.EN_read_prt_entry, 0);
    end
    if (bus.EN_invalidate_prt_entry) begin
      chk("inv_rdy", bus.RDY_invalidate_prt_entry, 1);
      chk("inv_expected", exp_outcome != 0, 1);
      chk("inv_slot", bus.invalidate_prt_entry_slot, cur_slot);
      if (exp_outcome == 2) chk("timeout_not_early", wait_k > TO, 1);
      done = 1;
    end
  endtask

  // vd: verdict delay after bf_enable (0 = never), bd: delay of a wrong-tag verdict (0 = none).
  task automatic run_pkt(input int n, input logic [SW-1:0] slot, input int vd, input bit safe,
                         input int bd, input int abort_at, input bit fixed_ip);
    clear_env();
    for (int i = 0; i < n; i++) pkt.push_back($urandom);
    if (fixed_ip && n > SRCB) pkt[SRCB] = 32'h0A000001;
    if (fixed_ip && n > DSTB) pkt[DSTB] = 32'h0A000002;
    n_beats = n; cur_slot = slot; verdict_d = vd; verdict_safe = safe; bad_d = bd;
    lookup_exp  = (n > DSTB) && (n <= MAXB);
    exp_outcome = !lookup_exp ? 1 : (vd == 0 || vd > TO) ? 2 : (safe ? 0 : 1);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      drive();
      @(negedge clk);
      sample();
      if (abort_at >= 0 && in_idx >= abort_at) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!aborted) begin
      if (!done) chk("pkt_done_in_budget", done, 1);
      else begin
        if (exp_outcome == 0) m_fwd++;
        else m_drop++;
        if (exp_outcome == 2) m_to++;
      end
      bus.in_valid = 0; bus.bf_output_valid = 0; bus.RDY_read_prt_entry = 0;
      @(negedge clk);
      chk("fwd_count", fwd_count, m_fwd);
      chk("drop_count", drop_count, m_drop);
      chk("timeout_count", timeout_count, m_to);
      chk("writes", wr_q.size(), (n < MAXB) ? n : MAXB);
      chk("consumed", in_idx, n);
      chk("finish_once", fin_cnt, 1);
      chk("lookup_issued", lookup_seen, lookup_exp);
      chk("out_beats", out_idx, (exp_outcome == 0) ? n : 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    do_reset();
    // Safe 8-beat packet into slot 5.
    run_pkt(8, 4'd5, 4, 1, 0, -1, 1);
    chk("t1_fwd_lit", fwd_count, 1);
    chk("t1_writes_lit", wr_q.size(), 8);
    chk("t1_src_lit", bus.bf_src_ip, 32'h0A000001);
    chk("t1_dst_lit", bus.bf_dest_ip, 32'h0A000002);
    do_reset();
    run_pkt(8, 4'd5, 4, 0, 0, -1, 1);
    chk("t2_drop_lit", drop_count, 1);
    chk("t2_fwd_lit", fwd_count, 0);
    do_reset();
    run_pkt(3, 4'd5, 4, 1, 0, -1, 1);
    chk("t3_drop_lit", drop_count, 1);
    chk("t3_writes_lit", wr_q.size(), 3);
    chk("t3_no_bf_lit", lookup_seen, 0);
    do_reset();
    run_pkt(70, 4'd5, 4, 1, 0, -1, 1);
    chk("t4_writes_lit", wr_q.size(), 64);
    chk("t4_consumed_lit", in_idx, 70);
    chk("t4_drop_lit", drop_count, 1);
    do_reset();
    run_pkt(8, 4'd5, 0, 1, 40, -1, 1);
    chk("t5_timeout_lit", timeout_count, 1);
    chk("t5_drop_lit", drop_count, 1);
    do_reset();
    // Verdict in the very cycle the timer expires must still be honoured.
    run_pkt(8, 4'd5, TO, 1, 0, -1, 1);
    chk("t6_fwd_lit", fwd_count, 1);
    chk("t6_timeout_lit", timeout_count, 0);
    do_reset();
    run_pkt(8, 4'd2, 3, 1, 0, -1, 0);
    run_pkt(20, 4'd7, 4, 1, 0, 6, 0);
    do_reset();
    run_pkt(8, 4'd9, 3, 1, 0, -1, 0);
    chk("t7_fwd_after_rst_lit", fwd_count, 1);
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int n, vd, bd;
      n  = rb(15) ? $urandom_range(60, 72) : $urandom_range(1, 20);
      vd = rb(10) ? 0 : $urandom_range(1, 30);
      bd = rb(30) ? $urandom_range(1, 25) : 0;
      run_pkt(n, 4'($urandom_range(15)), vd, rb(60), bd, -1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
